// File: rtl/lpm_pack_pkg.sv
// lpm_pack_pkg: shared types and default sizes for the LPM word packer.
//   lpm_pack_state_e : framing FSM states (HDR, BODY, DRAIN)
//   lpm_msg_t        : request pipe message {tag, payload} at default widths
package lpm_pack_pkg;

  localparam int LPM_WORD_W = 32;
  localparam int LPM_TAG_W  = 16;
  localparam int LPM_DATA_W = 128;
  localparam int LPM_NWORDS = LPM_DATA_W / LPM_WORD_W;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    BODY  = 2'd1,
    DRAIN = 2'd2
  } lpm_pack_state_e;

  typedef struct packed {
    logic [LPM_TAG_W-1:0]  tag;
    logic [LPM_DATA_W-1:0] payload;
  } lpm_msg_t;

endpackage

// File: rtl/lpm_pack_outreg.sv
// lpm_pack_outreg: single-entry output holding register with valid/ready.
//   CLK, RST      : clock, synchronous active-high reset
//   load          : capture load_data this cycle (caller guarantees a slot)
//   load_data     : message to hold
//   out_rdy       : consumer accepts the held message
//   out_vld       : a message is held (also serves as the "full" flag)
//   out_data      : held message, stable while out_vld && !out_rdy
module lpm_pack_outreg #(
  parameter int MSG_W = 144
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [MSG_W-1:0] load_data,
  input  logic             out_rdy,
  output logic             out_vld,
  output logic [MSG_W-1:0] out_data
);

  logic             vld_q, vld_d;
  logic [MSG_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q && !out_rdy;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;

endmodule

// File: rtl/lpm_word_packer.sv
// lpm_word_packer: packs a host word stream into {tag, payload} pipe messages.
//   CLK, RST                 : clock, synchronous active-high reset
//   in_valid/in_data/in_last : host word stream; in_ready accepts a word
//   enq__ENA/enq_v/enq__RDY  : message toward the request pipe
//   drop                     : one-cycle pulse when a malformed frame is discarded
// Frame: header word (tag in low bits), then NWORDS payload words, word 1 in LSBs,
// in_last only on the final payload word. Short/1-word frames drop at the
// in_last word; long frames drop at word NWORDS and drain to the next in_last.
// Optional macro LPM_PACK_STATS_EN adds frames_ok / frames_dropped counters.
module lpm_word_packer
  import lpm_pack_pkg::*;
#(
  parameter int WORD_WIDTH = LPM_WORD_W,
  parameter int TAG_WIDTH  = LPM_TAG_W,
  parameter int DATA_WIDTH = LPM_DATA_W
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_valid,
  input  logic [WORD_WIDTH-1:0]         in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          enq__ENA,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] enq_v,
  input  logic                          enq__RDY,
  output logic                          drop
`ifdef LPM_PACK_STATS_EN
  ,
  output logic [31:0]                   frames_ok,
  output logic [15:0]                   frames_dropped
`endif
);

  localparam int NWORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IW     = $clog2(NWORDS + 1);
  localparam int PW     = DATA_WIDTH - WORD_WIDTH;  // payload held before the last word
  localparam int MSG_W  = TAG_WIDTH + DATA_WIDTH;

  lpm_pack_state_e        state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [PW-1:0]          payload_q, payload_d;

  logic                   out_full;
  logic                   commit_ok;
  logic                   commit;
  logic                   acc;
  logic [MSG_W-1:0]       msg;

  // The final payload word goes straight into the output register, so only
  // words 1..NWORDS-1 need assembly storage.
  assign msg = {tag_q, in_data, payload_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    payload_d = payload_q;
    drop      = 1'b0;
    commit    = 1'b0;

    // A full output slot can still take a commit if it empties this cycle.
    commit_ok = !out_full || enq__RDY;
    in_ready  = !RST && !(state_q == BODY && idx_q == IW'(NWORDS) && !commit_ok);
    acc       = in_valid && in_ready;

    if (acc) begin
      unique case (state_q)
        HDR: begin
          if (in_last) begin
            drop = 1'b1;
          end else begin
            tag_d   = in_data[TAG_WIDTH-1:0];
            idx_d   = IW'(1);
            state_d = BODY;
          end
        end
        BODY: begin
          if (idx_q == IW'(NWORDS)) begin
            idx_d = '0;
            if (in_last) begin
              commit  = 1'b1;
              state_d = HDR;
            end else begin
              drop    = 1'b1;
              state_d = DRAIN;
            end
          end else if (in_last) begin
            drop    = 1'b1;
            idx_d   = '0;
            state_d = HDR;
          end else begin
            for (int k = 0; k < NWORDS - 1; k++) begin
              if (idx_q == IW'(k + 1)) payload_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
            end
            idx_d = idx_q + IW'(1);
          end
        end
        DRAIN: begin
          if (in_last) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HDR;
      idx_q     <= '0;
      tag_q     <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      payload_q <= payload_d;
    end
  end

  lpm_pack_outreg #(
    .MSG_W(MSG_W)
  ) u_outreg (
    .CLK      (CLK),
    .RST      (RST),
    .load     (commit),
    .load_data(msg),
    .out_rdy  (enq__RDY),
    .out_vld  (out_full),
    .out_data (enq_v)
  );

  assign enq__ENA = out_full;

`ifdef LPM_PACK_STATS_EN
  logic [31:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_dropped_q, frames_dropped_d;

  always_comb begin
    frames_ok_d      = frames_ok_q + {31'd0, commit};
    frames_dropped_d = frames_dropped_q;
    if (drop && frames_dropped_q != 16'hFFFF) frames_dropped_d = frames_dropped_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      frames_ok_q      <= '0;
      frames_dropped_q <= '0;
    end else begin
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;
`endif

endmodule

// File: tb/tb_lpm_word_packer.sv
module tb_lpm_word_packer;
  import lpm_pack_pkg::*;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic         enq__ENA;
  logic [143:0] enq_v;
  logic         enq__RDY;
  logic         drop;
`ifdef LPM_PACK_STATS_EN
  logic [31:0]  frames_ok;
  logic [15:0]  frames_dropped;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int drop_cnt = 0;
  logic last_drop;

  always #5 CLK = ~CLK;

  lpm_word_packer dut (
    .CLK     (CLK),
    .RST     (RST),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_last (in_last),
    .in_ready(in_ready),
    .enq__ENA(enq__ENA),
    .enq_v   (enq_v),
    .enq__RDY(enq__RDY),
    .drop    (drop)
`ifdef LPM_PACK_STATS_EN
    ,
    .frames_ok     (frames_ok),
    .frames_dropped(frames_dropped)
`endif
  );

  task automatic chk(input string tag, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Presents one word, waits (bounded) for in_ready, records drop at acceptance.
  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= 100) chk("in_ready_timeout", 144'(in_ready), 144'd1);
    last_drop = drop;
    drop_cnt += int'(drop);
    @(posedge CLK); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] tag, input logic [127:0] p);
    send_word({16'hABCD, tag}, 1'b0);
    for (int k = 0; k < 4; k++) send_word(p[k*32 +: 32], k == 3);
  endtask

  function automatic logic [143:0] mk(input logic [15:0] tag, input logic [127:0] p);
    lpm_msg_t m;
    m.tag = tag; m.payload = p;
    return m;
  endfunction

  localparam logic [127:0] P1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] PA = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
  localparam logic [127:0] PB = 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1;
  localparam logic [127:0] PC = 128'hC0DEC0DE_0BADF00D_DEADBEEF_12345678;

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; enq__RDY = 1'b1;
    last_drop = 1'b0;
    @(posedge CLK); #2;
    chk("rst_in_ready", 144'(in_ready), 144'd0);
    chk("rst_ena",      144'(enq__ENA), 144'd0);
    chk("rst_enq_v",    enq_v, 144'd0);
    chk("rst_drop",     144'(drop), 144'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_in_ready", 144'(in_ready), 144'd1);

    // Clean frame, message one cycle after the last word
    send_word(32'h0000_0003, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_word(32'h3333_3333, 1'b0);
    send_word(32'h4444_4444, 1'b1);
    chk("clean_ena", 144'(enq__ENA), 144'd1);
    chk("clean_v",   enq_v, {16'h0003, 128'h44444444_33333333_22222222_11111111});
    chk("clean_drop_cnt", 144'(drop_cnt), 144'd0);
    @(posedge CLK); #1;
    chk("clean_ena_clear", 144'(enq__ENA), 144'd0);

    // Back-to-back frames at full rate
    send_frame(16'h0021, PC);
    chk("b2b_first_v", enq_v, mk(16'h0021, PC));
    send_frame(16'h0022, P1);
    chk("b2b_second_ena", 144'(enq__ENA), 144'd1);
    chk("b2b_second_v", enq_v, mk(16'h0022, P1));
    @(posedge CLK); #1;

    // Backpressure: A held, B stalls at its last word, then both in order
    enq__RDY = 1'b0;
    send_frame(16'h00A5, PA);
    chk("bp_a_ena", 144'(enq__ENA), 144'd1);
    chk("bp_a_v", enq_v, mk(16'h00A5, PA));
    send_word(32'h0000_00B6, 1'b0);
    for (int k = 0; k < 3; k++) send_word(PB[k*32 +: 32], 1'b0);
    in_valid = 1'b1; in_data = PB[127:96]; in_last = 1'b1;
    #1;
    chk("bp_last_stall", 144'(in_ready), 144'd0);
    repeat (12) begin @(posedge CLK); #1; end
    chk("bp_a_stable", enq_v, mk(16'h00A5, PA));
    chk("bp_still_stall", 144'(in_ready), 144'd0);
    enq__RDY = 1'b1;
    #1;
    chk("bp_release_ready", 144'(in_ready), 144'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_b_ena", 144'(enq__ENA), 144'd1);
    chk("bp_b_v", enq_v, mk(16'h00B6, PB));
    @(posedge CLK); #1;
    chk("bp_drained", 144'(enq__ENA), 144'd0);

    // Short frame: header + 2 payload words
    drop_cnt = 0;
    send_word(32'h0000_0007, 1'b0);
    send_word(32'h5555_5555, 1'b0);
    send_word(32'h6666_6666, 1'b1);
    chk("short_drop_cnt", 144'(drop_cnt), 144'd1);
    chk("short_no_ena", 144'(enq__ENA), 144'd0);
    send_frame(16'h0031, PC);
    chk("short_next_v", enq_v, mk(16'h0031, PC));
    chk("short_next_ena", 144'(enq__ENA), 144'd1);

    // Long frame: 7 words, drop on the 5th, rest drained
    drop_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      send_word(32'h7700_0000 + k, k == 7);
      if (k == 5) chk("long_drop_w5", 144'(last_drop), 144'd1);
    end
    chk("long_drop_cnt", 144'(drop_cnt), 144'd1);
    chk("long_no_ena", 144'(enq__ENA), 144'd0);
    send_frame(16'h0041, PA);
    chk("long_next_v", enq_v, mk(16'h0041, PA));

    // 1-word frame drops
    drop_cnt = 0;
    send_word(32'h0000_0009, 1'b1);
    chk("one_word_drop", 144'(drop_cnt), 144'd1);

    // Reset mid-frame
    drop_cnt = 0;
    send_word(32'h0000_0051, 1'b0);
    send_word(32'h8888_8888, 1'b0);
    send_word(32'h9999_9999, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rstmid_no_ena", 144'(enq__ENA), 144'd0);
    send_frame(16'h0052, PB);
    chk("rstmid_next_v", enq_v, mk(16'h0052, PB));
    chk("rstmid_no_drop", 144'(drop_cnt), 144'd0);

`ifdef LPM_PACK_STATS_EN
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    send_frame(16'h0061, P1);
    send_word(32'h0000_0062, 1'b0);
    send_word(32'h1234_5678, 1'b1);
    send_frame(16'h0063, PA);
    for (int k = 1; k <= 6; k++) send_word(32'h6600_0000 + k, k == 6);
    send_frame(16'h0064, PB);
    @(posedge CLK); #1;
    chk("stats_ok",   144'(frames_ok), 144'd3);
    chk("stats_drop", 144'(frames_dropped), 144'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lpm_word_packer.md
Name: lpm_word_packer

Overview:
- Upstream framing stage for the LPM request pipe.
- Packs a 32-bit host word stream into one 144-bit pipe message, {16-bit method tag, 128-bit payload}, and presents it on a PipeIn-style enq handshake.
- Its output connects directly to the top-level request pipe server port that feeds the request pipe-to-method converter.
- Detects malformed frames, drops them, and resynchronises on the next frame.

Parameters:
- WORD_WIDTH, 32, host word width.
- TAG_WIDTH, 16, method tag width; carried in header word bits [TAG_WIDTH-1:0].
- DATA_WIDTH, 128, payload width; must be a multiple of WORD_WIDTH.
- NWORDS, DATA_WIDTH/WORD_WIDTH (4), payload words per frame (derived localparam).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  host word valid
- in_data  in  WORD_WIDTH  host word
- in_last  in  1  final word of host frame
- in_ready  out  1  packer accepts word this cycle
- enq__ENA  out  1  message valid toward request pipe
- enq_v  out  TAG_WIDTH+DATA_WIDTH  message {tag, payload}
- enq__RDY  in  1  request pipe can accept
- drop  out  1  one-cycle pulse: malformed frame discarded

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high; all state is updated on the rising edge of CLK.
- Word transfer: a word transfers when in_valid && in_ready. Message transfer: a message transfers when enq__ENA && enq__RDY.
- Frame format:
  - Word 0 is the header: tag = in_data[TAG_WIDTH-1:0]; the upper bits are ignored.
  - Words 1..NWORDS are payload. Payload word k lands in payload[(k-1)*WORD_WIDTH +: WORD_WIDTH], so word 1 is the LSBs.
  - in_last is set on word NWORDS only.
- Storage: assembly register (tag, payload, word index idx 0..NWORDS) plus one output holding register (out_full). Double buffered: the next frame assembles while the previous one waits on enq__RDY.
- FSM states: HDR, BODY, DRAIN.
  - HDR: accepting a word with in_last=0 latches the tag, sets idx=1, goes to BODY. Accepting with in_last=1 is a 1-word frame: pulse drop, stay in HDR.
  - BODY, accepting word idx < NWORDS: in_last=1 pulses drop and returns to HDR (short frame); otherwise store the word, idx++.
  - BODY, accepting word idx == NWORDS with in_last=1: the frame is complete; commit to the output register (rules below) and go to HDR.
  - BODY, accepting word idx == NWORDS with in_last=0: the frame is too long; pulse drop and go to DRAIN.
  - DRAIN: accept and discard words; on an accepted in_last=1 go to HDR. No second drop pulse is issued.
- Commit to output register:
  - Allowed when out_full=0, or when out_full=1 and the output transfer happens in the same cycle.
  - in_ready is 0 in BODY at idx==NWORDS unless commit is allowed. Frames are never lost to backpressure.
  - In HDR, BODY (idx<NWORDS) and DRAIN, in_ready=1 regardless of output state.
- Latency and throughput:
  - The final word accepted in cycle N gives enq__ENA=1 in cycle N+1.
  - Sustained rate is one message per NWORDS+1 input cycles with enq__RDY held at 1.
- Output stability: enq_v is stable while enq__ENA=1 && enq__RDY=0. enq__ENA deasserts the cycle after a transfer unless a new commit occurred.
- Reset values: enq__ENA=0, enq_v=0, in_ready=0 during the RST cycle then 1, drop=0, state=HDR, idx=0, out_full=0.
- Reset mid-frame: partial assembly discarded and the held output message discarded; no drop pulse.

Optional Feature:
- Macro LPM_PACK_STATS_EN.
- Defined: adds outputs frames_ok (32-bit) and frames_dropped (16-bit), each cleared by RST.
  - frames_ok increments on each commit.
  - frames_dropped increments on each drop pulse and saturates at 16'hFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package lpm_pack_pkg holds:
  - the state enum typedef (HDR, BODY, DRAIN);
  - the message struct typedef {tag, payload};
  - localparams for the default widths and NWORDS.
- One sub-module, lpm_pack_outreg: the single-entry output holding register with valid/ready semantics.
- The FSM and assembly register live in the top module.

Test Plan:
- Clean frame: words 0x0000_0003, 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on the 5th), enq__RDY=1 -> cycle after the last word, enq__ENA=1, enq_v={16'h0003, 128'h44444444_33333333_22222222_11111111}.
- Backpressure: enq__RDY=0 for 20 cycles, send two clean frames -> first message held stable; in_ready=0 at the second frame's final word; both messages delivered in order once enq__RDY=1.
- Short frame: header plus 2 payload words, last on the 3rd word -> drop pulses once; no enq__ENA; the following clean frame is delivered correctly.
- Long frame: 7 words, last on the 7th -> drop pulses on the 5th word; words 6-7 discarded; the next clean frame is delivered.
- Reset mid-frame: RST after the header and 2 payload words -> no output; the next clean frame is delivered intact.
- LPM_PACK_STATS_EN defined: 3 clean frames and 2 malformed frames -> frames_ok=3, frames_dropped=2.
